// File: rtl/sweep_pkg.sv
// Shared constants for the truth-table sweep stage: widths, state encoding, golden masks.
package sweep_pkg;

  localparam int unsigned TT_W   = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned SCNT_W = 4;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  // Golden truth tables per function variant; bit i = F(ABCD=i)
  localparam logic [TT_W-1:0] TT_POS_4V = 16'hADA8;

endpackage

// File: rtl/truth_table_sweeper.sv
// Walks a 4-input Boolean block through all 16 vectors, captures its output
// into a truth table and compares it against a golden mask.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned     SETTLE_CYC = 1,
  parameter logic [TT_W-1:0] EXPECTED   = TT_POS_4V
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              f_in,
  output logic [IDX_W-1:0]  abcd,
  output logic              busy,
  output logic              done,
  output logic [TT_W-1:0]   tt,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam logic [SCNT_W-1:0] LAST_SCNT = SCNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TT_W - 1);

  sweep_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [IDX_W-1:0]  abcd_d;
  logic              busy_d;
  logic              done_d;
  logic [TT_W-1:0]   tt_d;
  logic              pass_d;
  logic [CNT_W-1:0]  mismatch_cnt_d;

  // State, counters and all outputs registered; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      scnt_q       <= '0;
      abcd         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tt           <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      scnt_q       <= scnt_d;
      abcd         <= abcd_d;
      busy         <= busy_d;
      done         <= done_d;
      tt           <= tt_d;
      pass         <= pass_d;
      mismatch_cnt <= mismatch_cnt_d;
    end
  end

  // Next-state, counter and capture logic; everything holds unless a transition says otherwise
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    scnt_d         = scnt_q;
    abcd_d         = abcd;
    busy_d         = busy;
    done_d         = 1'b0;
    tt_d           = tt;
    pass_d         = pass;
    mismatch_cnt_d = mismatch_cnt;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = APPLY;
          idx_d          = '0;
          scnt_d         = '0;
          abcd_d         = '0;
          busy_d         = 1'b1;
          tt_d           = '0;
          pass_d         = 1'b0;
          mismatch_cnt_d = '0;
        end
      end

      APPLY: begin
        if (scnt_q == LAST_SCNT) begin
          // Last hold cycle of this vector: Y has settled, capture it
          tt_d[idx_q] = f_in;
          if (f_in != EXPECTED[idx_q]) begin
            mismatch_cnt_d = mismatch_cnt + CNT_W'(1);
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (tt_d == EXPECTED);
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            scnt_d = '0;
            abcd_d = idx_q + IDX_W'(1);
          end
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
